attribute_interpolator: RTL and testbench
=========================================

Name: attribute_interpolator

Overview:
Downstream consumer of the barycentric weight stage. Takes the three per-pixel weights (w0, w1, w2) plus the per-vertex colour attributes of the current triangle, and produces the perspective-free interpolated colour for that pixel. Uses a single time-shared multiply-accumulate unit over NUM_CH channels × 3 vertices. Result goes to the pixel write/framebuffer stage.

Parameters:
ATTR_W, 8, bits per colour channel (unsigned)
NUM_CH, 3, channels per vertex (R,G,B packed, channel 0 in LSBs)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  weights and attributes valid
in_ready  out  1  block can accept (state IDLE)
w0  in  32  weight for vertex 0
w1  in  32  weight for vertex 1
w2  in  32  weight for vertex 2
c0  in  NUM_CH*ATTR_W  vertex 0 colour, packed
c1  in  NUM_CH*ATTR_W  vertex 1 colour, packed
c2  in  NUM_CH*ATTR_W  vertex 2 colour, packed
out_valid  out  1  result valid; held until out_ready
out_ready  in  1  downstream accepts
color  out  NUM_CH*ATTR_W  interpolated colour, packed
busy  out  1  high in MAC or DONE

Behaviour:
- Reset (async, immediate): state=IDLE; out_valid=0, busy=0, color=0; accumulator, counters and latched operands cleared. Reset mid-operation discards the pixel; no partial output.
- Weight format: unsigned Q1.16 in w[16:0], 1.0 = 0x10000. w[31]=1 (negative, outside edge) → weight treated as 0. w[31]=0 with w[30:17]≠0 → clamp to 0x1FFFF.
- States: IDLE → MAC → DONE → IDLE.
- IDLE: in_ready=1. On in_valid (cycle T), latch clamped weights and all attributes → MAC, ch=0, v=0, acc=0.
- MAC: one product per cycle, order ch0 v0,v1,v2; ch1 v0..v2; …; 3*NUM_CH cycles (9 by default), T+1..T+9. acc width ATTR_W+19 bits, unsigned. After v2 of each channel: result = (acc + 0x8000) >> 16, saturate to 2^ATTR_W−1, write into the color channel slice, clear acc.
- color channels update only at their own write. Full result valid at transition to DONE.
- DONE: out_valid=1 from T+10. Held stable with color while out_ready=0. On out_ready → IDLE next cycle. Earliest next accept is the cycle after that (T+11 with out_ready tied high). in_valid is ignored in DONE and MAC.
- in_valid is a level signal; inputs sampled only in the accept cycle. Upstream may change them afterwards.
- color retains the last result after the handshake, until overwritten or reset.
- Weights need not sum to 1.0. Saturation covers sums > 1.0.

Optional Feature:
DEPTH_INTERP_EN:
- Defined: adds inputs z0, z1, z2 (16-bit unsigned) and output depth (16-bit). Adds one extra channel after colour (3 more MAC cycles). Same rounding. Saturates to 0xFFFF. out_valid moves to T+13. Reset value of depth is 0.
- Undefined: no depth ports; latency as above.

Decomposition:
- Package interp_pkg: Q1.16 ONE=0x10000, WEIGHT_FRAC=16, ROUND_HALF=0x8000, state encoding (IDLE/MAC/DONE), ACC_W function of ATTR_W.
- One sub-module: interp_mac. Takes a clamped 17-bit weight and an attribute. Holds the accumulator with clear/accumulate and round/saturate output. The top level holds the FSM, counters and operand muxing.

Test Plan:
- Single pixel: w0=0x8000, w1=0x4000, w2=0x4000; R: c0=200, c1=100, c2=0; G all 10; B: c0=0, c1=0, c2=255 → color R=125, G=10, B=64 (63.75 rounded). out_valid at T+10.
- Vertex hit: w0=0x10000, w1=w2=0; c0=(17,34,51) → color=(17,34,51) exactly.
- Saturation/clamp: w0=w1=w2=0x0001FFFF, all attrs 255 → 255 on every channel. w1=0xFFFF0000 (negative) with w0=0x10000 → equals c0.
- Backpressure: out_ready low for 5 cycles after out_valid → color and out_valid stable, in_ready=0, in_valid pulses ignored. Release → next pixel accepted one cycle after the handshake.
- Reset mid-MAC: assert rst at T+4 → out_valid=0, color=0, in_ready=1 after release. A new pixel completes normally.
- Back-to-back: 4 pixels with out_ready tied high → one result every 11 cycles, values match the reference model. Repeat with DEPTH_INTERP_EN, z0=1000, z1=3000, z2=0, weights 0.5/0.5/0 → depth=2000.

Source files
------------

// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared constants, state encoding and weight clamp for attribute_interpolator
//
// Purpose: Q1.16 weight constants, rounding constant, FSM state type,
//          accumulator width helper and the weight clamp used at accept time.
// Ports:   none (package).
package interp_pkg;

  localparam int WEIGHT_W    = 17;
  localparam int WEIGHT_FRAC = 16;
  localparam int DEPTH_W     = 16;
  localparam int ROUND_HALF  = 'h8000;

  localparam logic [WEIGHT_W-1:0] ONE        = 17'h10000;
  localparam logic [WEIGHT_W-1:0] WEIGHT_MAX = 17'h1FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Three products of a 17-bit weight (< 2^17) and an attribute (< 2^attr_w)
  // stay below 2^(attr_w+19).
  function automatic int acc_w(input int attr_w);
    return attr_w + 19;
  endfunction

  // Negative weights (outside the edge) contribute nothing; anything at or
  // above 2.0 is pinned to the largest representable Q1.16 value.
  function automatic logic [WEIGHT_W-1:0] clamp_weight(input logic [31:0] w);
    if (w[31]) begin
      return '0;
    end else if (|w[30:17]) begin
      return WEIGHT_MAX;
    end else begin
      return w[16:0];
    end
  endfunction

endpackage

// File: rtl/interp_mac.sv
// rtl/interp_mac.sv - time-shared multiply-accumulate with round/saturate result
//
// Purpose: accumulates weight*attr products; result is the rounded,
//          saturated value of (acc + current product), valid on the last term.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             zero the accumulator (new pixel)
//   en              add current product to the accumulator
//   last            this product closes the channel; accumulator is cleared
//   weight          clamped Q1.16 weight
//   attr            attribute value (zero-extended to OP_W)
//   sat_max         saturation ceiling for this channel
//   result          round((acc + weight*attr) / 2^16), limited to sat_max
module interp_mac
  import interp_pkg::*;
#(
  parameter int OP_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                last,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic [OP_W-1:0]     attr,
  input  logic [OP_W-1:0]     sat_max,
  output logic [OP_W-1:0]     result
);

  localparam int AW = acc_w(OP_W);
  localparam int PW = WEIGHT_W + OP_W;
  localparam int RW = AW + 1;
  localparam int QW = RW - WEIGHT_FRAC;

  logic [AW-1:0] acc_q, acc_d;
  logic [PW-1:0] prod;
  logic [AW-1:0] sum;
  logic [RW-1:0] rounded;
  logic [QW-1:0] quot;

  always_comb begin
    prod    = {{OP_W{1'b0}}, weight} * {{WEIGHT_W{1'b0}}, attr};
    sum     = acc_q + AW'(prod);
    rounded = {1'b0, sum} + RW'(ROUND_HALF);
    quot    = rounded[RW-1:WEIGHT_FRAC];
    result  = (quot > QW'(sat_max)) ? sat_max : quot[OP_W-1:0];
  end

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = last ? '0 : sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/attribute_interpolator.sv
// rtl/attribute_interpolator.sv - barycentric colour (and optional depth) interpolator
//
// Purpose: latches three clamped weights and per-vertex attributes, then runs
//          one MAC per cycle (channel-major, vertex-minor) and presents the
//          interpolated colour until the downstream handshake.
// Build option: DEPTH_INTERP_EN adds z0/z1/z2 inputs and a depth output,
//          interpolated as one extra channel after colour.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    input handshake (ready only in IDLE)
//   w0, w1, w2             per-pixel weights (Q1.16 in [16:0], sign in [31])
//   c0, c1, c2             packed vertex colours, channel 0 in LSBs
//   z0, z1, z2             vertex depths (DEPTH_INTERP_EN only)
//   out_valid / out_ready  output handshake, result held while not ready
//   color                  interpolated packed colour
//   depth                  interpolated depth (DEPTH_INTERP_EN only)
//   busy                   high while computing or holding a result
module attribute_interpolator
  import interp_pkg::*;
#(
  parameter int ATTR_W = 8,
  parameter int NUM_CH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              w0,
  input  logic [31:0]              w1,
  input  logic [31:0]              w2,
  input  logic [NUM_CH*ATTR_W-1:0] c0,
  input  logic [NUM_CH*ATTR_W-1:0] c1,
  input  logic [NUM_CH*ATTR_W-1:0] c2,
`ifdef DEPTH_INTERP_EN
  input  logic [DEPTH_W-1:0]       z0,
  input  logic [DEPTH_W-1:0]       z1,
  input  logic [DEPTH_W-1:0]       z2,
  output logic [DEPTH_W-1:0]       depth,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*ATTR_W-1:0] color,
  output logic                     busy
);

`ifdef DEPTH_INTERP_EN
  localparam int NUM_PASS = NUM_CH + 1;
  localparam int OP_W     = (ATTR_W > DEPTH_W) ? ATTR_W : DEPTH_W;
`else
  localparam int NUM_PASS = NUM_CH;
  localparam int OP_W     = ATTR_W;
`endif
  localparam int CH_W  = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
  localparam int COL_W = NUM_CH * ATTR_W;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [1:0]          v_q, v_d;
  logic [WEIGHT_W-1:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [COL_W-1:0]    c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
  logic [COL_W-1:0]    color_q, color_d;
`ifdef DEPTH_INTERP_EN
  logic [DEPTH_W-1:0]  z0_q, z0_d, z1_q, z1_d, z2_q, z2_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [DEPTH_W-1:0]  z_sel;
`endif

  logic                mac_clr, mac_en, mac_last;
  logic [WEIGHT_W-1:0] mac_weight;
  logic [OP_W-1:0]     mac_attr, mac_sat, mac_result;
  logic [COL_W-1:0]    col_sel;

  // Operand select: vertex picks weight and colour word, channel picks slice.
  always_comb begin
    mac_weight = w0_q;
    col_sel    = c0_q;
`ifdef DEPTH_INTERP_EN
    z_sel      = z0_q;
`endif
    case (v_q)
      2'd1: begin
        mac_weight = w1_q;
        col_sel    = c1_q;
`ifdef DEPTH_INTERP_EN
        z_sel      = z1_q;
`endif
      end
      2'd2: begin
        mac_weight = w2_q;
        col_sel    = c2_q;
`ifdef DEPTH_INTERP_EN
        z_sel      = z2_q;
`endif
      end
      default: ;
    endcase
    mac_attr = OP_W'(col_sel[ch_q*ATTR_W +: ATTR_W]);
    mac_sat  = OP_W'({ATTR_W{1'b1}});
`ifdef DEPTH_INTERP_EN
    // Depth is the pass after the last colour channel.
    if (ch_q == CH_W'(NUM_CH)) begin
      mac_attr = OP_W'(z_sel);
      mac_sat  = OP_W'({DEPTH_W{1'b1}});
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    v_d      = v_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    w2_d     = w2_q;
    c0_d     = c0_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    color_d  = color_q;
`ifdef DEPTH_INTERP_EN
    z0_d     = z0_q;
    z1_d     = z1_q;
    z2_d     = z2_q;
    depth_d  = depth_q;
`endif
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    mac_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          w0_d    = clamp_weight(w0);
          w1_d    = clamp_weight(w1);
          w2_d    = clamp_weight(w2);
          c0_d    = c0;
          c1_d    = c1;
          c2_d    = c2;
`ifdef DEPTH_INTERP_EN
          z0_d    = z0;
          z1_d    = z1;
          z2_d    = z2;
`endif
          ch_d    = '0;
          v_d     = '0;
          mac_clr = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (v_q == 2'd2) begin
          mac_last = 1'b1;
          v_d      = '0;
          if (ch_q < CH_W'(NUM_CH)) begin
            color_d[ch_q*ATTR_W +: ATTR_W] = mac_result[ATTR_W-1:0];
          end
`ifdef DEPTH_INTERP_EN
          if (ch_q == CH_W'(NUM_CH)) begin
            depth_d = mac_result[DEPTH_W-1:0];
          end
`endif
          if (ch_q == CH_W'(NUM_PASS - 1)) begin
            state_d = S_DONE;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else begin
          v_d = v_q + 2'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      v_q     <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      color_q <= '0;
`ifdef DEPTH_INTERP_EN
      z0_q    <= '0;
      z1_q    <= '0;
      z2_q    <= '0;
      depth_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      v_q     <= v_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      color_q <= color_d;
`ifdef DEPTH_INTERP_EN
      z0_q    <= z0_d;
      z1_q    <= z1_d;
      z2_q    <= z2_d;
      depth_q <= depth_d;
`endif
    end
  end

  interp_mac #(
    .OP_W(OP_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .en     (mac_en),
    .last   (mac_last),
    .weight (mac_weight),
    .attr   (mac_attr),
    .sat_max(mac_sat),
    .result (mac_result)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign color     = color_q;
`ifdef DEPTH_INTERP_EN
  assign depth     = depth_q;
`endif

endmodule

// File: tb/tb_attribute_interpolator.sv
// tb/tb_attribute_interpolator.sv - self-checking bench for attribute_interpolator
module tb_attribute_interpolator;

  localparam int ATTR_W = 8;
  localparam int NUM_CH = 3;
  localparam int COL_W  = ATTR_W * NUM_CH;
`ifdef DEPTH_INTERP_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 10;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0]      w0, w1, w2;
  logic [COL_W-1:0] c0, c1, c2, color;
`ifdef DEPTH_INTERP_EN
  logic [15:0]      z0, z1, z2, depth;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]      w0, w1, w2;
    logic [COL_W-1:0] c0, c1, c2;
    logic [COL_W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  attribute_interpolator #(
    .ATTR_W(ATTR_W),
    .NUM_CH(NUM_CH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .w0       (w0),
    .w1       (w1),
    .w2       (w2),
    .c0       (c0),
    .c1       (c1),
    .c2       (c2),
`ifdef DEPTH_INTERP_EN
    .z0       (z0),
    .z1       (z1),
    .z2       (z2),
    .depth    (depth),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .color    (color),
    .busy     (busy)
  );

  // Reference: weight = 0 if negative, min(w, 0x1FFFF) otherwise; each channel
  // is round-half-up of sum(weight*attr)/65536, capped at 255.
  function automatic longint clampw(input logic [31:0] w);
    if (w[31]) return 0;
    if (w > 32'h1FFFF) return 'h1FFFF;
    return longint'(w);
  endfunction

  function automatic logic [COL_W-1:0] model(input logic [31:0] a, b, c,
                                             input logic [COL_W-1:0] x, y, z);
    logic [COL_W-1:0] r;
    longint s;
    r = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      s = clampw(a) * longint'(x[ch*ATTR_W +: ATTR_W])
        + clampw(b) * longint'(y[ch*ATTR_W +: ATTR_W])
        + clampw(c) * longint'(z[ch*ATTR_W +: ATTR_W]);
      s = (s + 32768) / 65536;
      if (s > 255) s = 255;
      r[ch*ATTR_W +: ATTR_W] = s[ATTR_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_w();
    case ($urandom_range(0, 5))
      0:       return $urandom | 32'h8000_0000;
      1:       return ($urandom | 32'h0002_0000) & 32'h7FFF_FFFF;
      default: return 32'($urandom_range(0, 'h12000));
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    w0 = v.w0; w1 = v.w1; w2 = v.w2;
    c0 = v.c0; c1 = v.c1; c2 = v.c2;
`ifdef DEPTH_INTERP_EN
    z0 = '0; z1 = '0; z2 = '0;
`endif
  endtask

  task automatic scramble();
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    c0 = COL_W'($urandom); c1 = COL_W'($urandom); c2 = COL_W'($urandom);
  endtask

  // Called at a negedge in IDLE with inputs driven; returns at the negedge
  // where out_valid is first seen, having checked latency and colour.
  task automatic accept_and_wait(input string nm, input logic [COL_W-1:0] exp);
    int n;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(LAT));
    chk({nm, "_color"}, 64'(color), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [COL_W-1:0] exp;

    vecs[0] = '{32'h8000, 32'h4000, 32'h4000, 24'h000AC8, 24'h000A64, 24'hFF0A00, 24'h400A7D};
    vecs[1] = '{32'h10000, 32'h0, 32'h0, 24'h332211, 24'hFFFFFF, 24'h123456, 24'h332211};
    vecs[2] = '{32'h1FFFF, 32'h1FFFF, 32'h1FFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    vecs[3] = '{32'h10000, 32'hFFFF0000, 32'h0, 24'h805A14, 24'hFFFFFF, 24'h777777, 24'h805A14};
    vecs[4] = '{32'h0040_0000, 32'h0, 32'h0, 24'h000102, 24'hABCDEF, 24'h010203, 24'h000204};
    vecs[5] = '{32'h0, 32'h8000_0001, 32'h0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_color", 64'(color), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
`ifdef DEPTH_INTERP_EN
    chk("reset_depth", 64'(depth), 64'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      accept_and_wait($sformatf("vec%0d", i), vecs[i].exp);
      @(negedge clk);
    end

    // Backpressure: result held, input ignored, then next accept right after handshake.
    out_ready = 1'b0;
    drive(vecs[0]);
    accept_and_wait("bp", vecs[0].exp);
    for (int k = 0; k < 5; k++) begin
      scramble();
      in_valid = k[0];
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", k), 64'(out_valid), 64'(1));
      chk($sformatf("bp_hold_color%0d", k), 64'(color), 64'(vecs[0].exp));
      chk($sformatf("bp_hold_ready%0d", k), 64'(in_ready), 64'(0));
    end
    drive(vecs[1]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    chk("bp_release_valid", 64'(out_valid), 64'(0));
    accept_and_wait("bp_next", vecs[1].exp);
    @(negedge clk);

    // Reset at T+4 discards the pixel.
    drive(vecs[2]);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_color", 64'(color), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    drive(vecs[3]);
    accept_and_wait("after_rst", vecs[3].exp);
    @(negedge clk);

    // Back-to-back random pixels with in_valid held high and out_ready tied high.
    for (int k = 0; k < 8; k++) begin
      w0 = rand_w(); w1 = rand_w(); w2 = rand_w();
      c0 = COL_W'($urandom); c1 = COL_W'($urandom); c2 = COL_W'($urandom);
      exp = model(w0, w1, w2, c0, c1, c2);
      in_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid && n < 60);
      chk($sformatf("b2b_gap%0d", k), 64'(n), 64'((k == 0) ? LAT : LAT + 1));
      chk($sformatf("b2b_color%0d", k), 64'(color), 64'(exp));
    end
    in_valid = 1'b0;
    @(negedge clk);

`ifdef DEPTH_INTERP_EN
    w0 = 32'h8000; w1 = 32'h8000; w2 = 32'h0;
    c0 = 24'h102030; c1 = 24'h302010; c2 = 24'hFFFFFF;
    z0 = 16'd1000; z1 = 16'd3000; z2 = 16'd0;
    exp = model(w0, w1, w2, c0, c1, c2);
    accept_and_wait("depth", exp);
    chk("depth_value", 64'(depth), 64'(2000));
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
